// File: rtl/core_pkg.sv
// Shared definitions for core_ctrl: one-hot state encoding, trap cause codes
// and the decoder class flags latched by the controller.
package core_pkg;

  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] ST_IDLE      = 7'b000_0001;
  localparam logic [STATE_W-1:0] ST_FETCH     = 7'b000_0010;
  localparam logic [STATE_W-1:0] ST_DECODE    = 7'b000_0100;
  localparam logic [STATE_W-1:0] ST_EXECUTE   = 7'b000_1000;
  localparam logic [STATE_W-1:0] ST_MEMORY    = 7'b001_0000;
  localparam logic [STATE_W-1:0] ST_WRITEBACK = 7'b010_0000;
  localparam logic [STATE_W-1:0] ST_TRAP      = 7'b100_0000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_EXECUTE   = ST_EXECUTE,
    S_MEMORY    = ST_MEMORY,
    S_WRITEBACK = ST_WRITEBACK,
    S_TRAP      = ST_TRAP
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic nowb;
  } dec_flags_t;

  // Branches only write the register file when they also link (JAL/JALR).
  function automatic logic writes_reg(input dec_flags_t f);
    return !(f.store || (f.branch && !f.jal && !f.jalr) || f.nowb);
  endfunction

endpackage

// File: rtl/core_ctrl.sv
// Multi-cycle core controller: fetch/decode/execute/memory/writeback sequencing,
// PC update and retire count. Trap handling is compiled in with CORE_CTRL_TRAP_EN.
module core_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4,
  parameter int              RET_W        = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              I_REQ,
  output logic [XLEN-1:0]   I_ADDR,
  input  logic              I_ACK,
  input  logic [31:0]       I_RDATA,
  output logic [31:0]       INST,
  input  logic              DEC_LOAD,
  input  logic              DEC_STORE,
  input  logic              DEC_BRANCH,
  input  logic              DEC_JAL,
  input  logic              DEC_JALR,
  input  logic              DEC_NOWB,
  input  logic              DEC_ILLEGAL,
  input  logic              BR_TAKEN,
  input  logic [XLEN-1:0]   BR_TARGET,
  input  logic [XLEN-1:0]   JALR_TARGET,
  output logic              D_REQ,
  output logic              D_WE,
  input  logic              D_ACK,
  output logic              REG_WE,
  output logic              WB_SEL_MEM,
  output logic [XLEN-1:0]   PC,
  output logic [6:0]        STATE,
  output logic              TRAP,
  output logic [1:0]        TRAP_CAUSE,
  output logic [RET_W-1:0]  RETIRED
);

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      inst_q;
  logic [RET_W-1:0] retired_q;
  dec_flags_t       flags_q;
  logic             redirect_q;
  logic [XLEN-1:0]  target_q;
  logic             i_req_q;
  logic             d_req_q;
  logic             d_we_q;
  logic             reg_we_q;
  logic             wb_sel_mem_q;
`ifdef CORE_CTRL_TRAP_EN
  logic             trap_q;
  logic [1:0]       cause_q;
  logic             misalign_d;
`endif

  dec_flags_t       flags_d;
  logic             redirect_d;
  logic [XLEN-1:0]  target_d;
  logic [XLEN-1:0]  seq_pc_d;

  always_comb begin
    flags_d = '{load: DEC_LOAD, store: DEC_STORE, branch: DEC_BRANCH,
                jal: DEC_JAL, jalr: DEC_JALR, nowb: DEC_NOWB};
    // An illegal opcode that does not trap degrades to a non-writing NOP.
    if (DEC_ILLEGAL) begin
      flags_d      = '0;
      flags_d.nowb = 1'b1;
    end
    redirect_d = flags_q.jalr || flags_q.jal || (flags_q.branch && BR_TAKEN);
    target_d   = flags_q.jalr ? JALR_TARGET : BR_TARGET;
    seq_pc_d   = pc_q + XLEN'(PC_STEP);
`ifdef CORE_CTRL_TRAP_EN
    misalign_d = redirect_d && (PC_STEP == 4) && (target_d[1:0] != 2'b00);
`endif
  end

  // Redirect decision and target are captured in EXECUTE so the PC commit in
  // WRITEBACK does not depend on the ALU still holding its result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      inst_q       <= '0;
      retired_q    <= '0;
      flags_q      <= '0;
      redirect_q   <= 1'b0;
      target_q     <= '0;
      i_req_q      <= 1'b0;
      d_req_q      <= 1'b0;
      d_we_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      wb_sel_mem_q <= 1'b0;
`ifdef CORE_CTRL_TRAP_EN
      trap_q       <= 1'b0;
      cause_q      <= CAUSE_NONE;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          i_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (I_ACK) begin
            inst_q  <= I_RDATA;
            i_req_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          flags_q <= flags_d;
`ifdef CORE_CTRL_TRAP_EN
          if (DEC_ILLEGAL) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state_q <= S_EXECUTE;
          end
`else
          state_q <= S_EXECUTE;
`endif
        end
        S_EXECUTE: begin
          redirect_q <= redirect_d;
          target_q   <= target_d;
`ifdef CORE_CTRL_TRAP_EN
          if (misalign_d) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_MISALIGN;
          end else
`endif
          if (flags_q.load || flags_q.store) begin
            state_q <= S_MEMORY;
            d_req_q <= 1'b1;
            d_we_q  <= flags_q.store;
          end else begin
            state_q      <= S_WRITEBACK;
            reg_we_q     <= writes_reg(flags_q);
            wb_sel_mem_q <= flags_q.load;
          end
        end
        S_MEMORY: begin
          if (D_ACK) begin
            d_req_q      <= 1'b0;
            d_we_q       <= 1'b0;
            state_q      <= S_WRITEBACK;
            reg_we_q     <= writes_reg(flags_q);
            wb_sel_mem_q <= flags_q.load;
          end
        end
        S_WRITEBACK: begin
          reg_we_q     <= 1'b0;
          wb_sel_mem_q <= 1'b0;
          pc_q         <= redirect_q ? target_q : seq_pc_d;
          retired_q    <= retired_q + RET_W'(1);
          state_q      <= S_FETCH;
          i_req_q      <= 1'b1;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q      <= S_IDLE;
          i_req_q      <= 1'b0;
          d_req_q      <= 1'b0;
          d_we_q       <= 1'b0;
          reg_we_q     <= 1'b0;
          wb_sel_mem_q <= 1'b0;
        end
      endcase
    end
  end

  assign I_REQ      = i_req_q;
  assign I_ADDR     = pc_q;
  assign INST       = inst_q;
  assign D_REQ      = d_req_q;
  assign D_WE       = d_we_q;
  assign REG_WE     = reg_we_q;
  assign WB_SEL_MEM = wb_sel_mem_q;
  assign PC         = pc_q;
  assign STATE      = state_q;
  assign RETIRED    = retired_q;
`ifdef CORE_CTRL_TRAP_EN
  assign TRAP       = trap_q;
  assign TRAP_CAUSE = cause_q;
`else
  assign TRAP       = 1'b0;
  assign TRAP_CAUSE = 2'd0;
`endif

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter RESET_VECTOR, default 0: PC value after reset.
REQ-003 Parameter PC_STEP, default 4: sequential PC increment (1 = word-addressed memory).
REQ-004 Parameter RET_W, default 32: retired-instruction counter width.
REQ-005 The ports SHALL be:
- CLK  in  1  clock.
- RST  in  1  reset; one clock, asynchronous and active-high.
- I_REQ  out  1  fetch request.
- I_ADDR  out  XLEN  fetch address.
- I_ACK  in  1  fetch complete.
- I_RDATA  in  32  fetched instruction.
- INST  out  32  latched instruction to decoder.
- DEC_LOAD, DEC_STORE, DEC_BRANCH, DEC_JAL, DEC_JALR, DEC_NOWB, DEC_ILLEGAL  in  1 each  decoder class flags.
- BR_TAKEN  in  1  branch condition from ALU.
- BR_TARGET, JALR_TARGET  in  XLEN each  computed targets.
- D_REQ  out  1  data access request.
- D_WE  out  1  data write.
- D_ACK  in  1  data access complete.
- REG_WE  out  1  register-file write strobe.
- WB_SEL_MEM  out  1  writeback selects load data.
- PC  out  XLEN  current PC.
- STATE  out  7  one-hot state.
- TRAP  out  1  sticky trap flag.
- TRAP_CAUSE  out  2  0 none, 1 illegal, 2 misaligned target.
- RETIRED  out  RET_W  retired-instruction count.

Function
REQ-006 States SHALL be one-hot: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
REQ-007 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-008 FETCH handshake:
- I_REQ=1 and I_ADDR=PC, both held stable until I_ACK=1.
- On the I_ACK cycle, I_RDATA is latched into INST and the state goes to DECODE.
REQ-009 DECODE SHALL last exactly one cycle, then go to EXECUTE.
REQ-010 EXECUTE SHALL last one cycle, then go to MEMORY if DEC_LOAD|DEC_STORE, else to WRITEBACK.
REQ-011 MEMORY handshake:
- D_REQ=1 and D_WE=DEC_STORE, held until D_ACK=1.
- On D_ACK the state goes to WRITEBACK.
- D_REQ=0 and D_WE=0 in every other state.
REQ-012 WRITEBACK SHALL last one cycle and then go to FETCH, with:
- REG_WE=1 unless DEC_STORE, DEC_BRANCH (without JAL/JALR) or DEC_NOWB is set;
- WB_SEL_MEM=DEC_LOAD.
REQ-013 PC update at the end of WRITEBACK, in priority order:
- JALR → JALR_TARGET;
- JAL, or BRANCH with BR_TAKEN → BR_TARGET;
- otherwise PC+PC_STEP, modulo 2^XLEN (wraps at all-ones).
REQ-014 RETIRED SHALL increment by 1 at each WRITEBACK exit and wrap at 2^RET_W.
REQ-015 An I_ACK or D_ACK arriving outside its request state SHALL be ignored.
REQ-016 TRAP state SHALL be absorbing until RST, with:
- TRAP=1;
- no requests and no REG_WE;
- PC frozen at the faulting instruction.

Reset
REQ-017 RST assertion SHALL immediately (asynchronously) force:
- state IDLE;
- PC=RESET_VECTOR;
- INST=0, RETIRED=0;
- TRAP=0, TRAP_CAUSE=0;
- all request and strobe outputs 0.
REQ-018 RST asserted mid-handshake SHALL abandon the transaction; no PC or register update is committed.

Configuration
REQ-019 With CORE_CTRL_TRAP_EN defined:
- DEC_ILLEGAL in DECODE goes to TRAP with cause 1.
- A redirect target with nonzero bits [1:0] when PC_STEP=4 goes to TRAP with cause 2 instead of WRITEBACK, and REG_WE stays 0.
REQ-020 Without CORE_CTRL_TRAP_EN:
- TRAP and TRAP_CAUSE SHALL be tied 0 and the TRAP state is unreachable.
- Illegal instructions execute as NOP: no REG_WE, PC+PC_STEP, RETIRED increments.

Structure
REQ-021 A shared package core_pkg SHALL hold the state encoding localparams and the TRAP_CAUSE codes.
REQ-022 The block SHALL be a single module with no sub-module; the handshake wait logic is inline.

Verification
REQ-023 Reset release, then ALU instruction with I_ACK 3 cycles late → I_ADDR=0 held 3 cycles, one REG_WE pulse, PC=4, RETIRED=1.
REQ-024 Store with D_ACK after 2 cycles → D_REQ=D_WE=1 for 3 cycles, REG_WE=0, PC advances by 4.
REQ-025 Taken branch with BR_TARGET=0x100, then JALR with JALR_TARGET=0x40 → PC=0x100 then 0x40, REG_WE only on JALR.
REQ-026 PC=0xFFFFFFFC, non-branch instruction → PC wraps to 0x0.
REQ-027 With CORE_CTRL_TRAP_EN: DEC_ILLEGAL=1 → TRAP=1, cause 1, PC frozen, no I_REQ for 20 cycles; without the macro → NOP, RETIRED increments.
REQ-028 RST pulse during MEMORY wait → state IDLE, PC=RESET_VECTOR, D_REQ=0 within the same cycle.
